// File: rtl/vga_frame_reader_pkg.sv
// Shared constants for the camera-to-VGA path: default 640x480@60 timing,
// RGB332 field positions and the RGB332 -> RGB444 expansion.
package vga_frame_reader_pkg;

  localparam int unsigned DEF_H_VIS  = 640;
  localparam int unsigned DEF_H_FP   = 16;
  localparam int unsigned DEF_H_SYNC = 96;
  localparam int unsigned DEF_H_BP   = 48;
  localparam int unsigned DEF_V_VIS  = 480;
  localparam int unsigned DEF_V_FP   = 10;
  localparam int unsigned DEF_V_SYNC = 2;
  localparam int unsigned DEF_V_BP   = 33;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned RGB_W  = 12;

  // RGB332 layout {R[2:0], G[2:0], B[1:0]}, shared with the capture stage.
  localparam int unsigned R_MSB = 7;
  localparam int unsigned R_LSB = 5;
  localparam int unsigned G_MSB = 4;
  localparam int unsigned G_LSB = 2;
  localparam int unsigned B_MSB = 1;
  localparam int unsigned B_LSB = 0;

  // Bit replication keeps full-scale codes at 4'hF and zero at zero.
  function automatic logic [RGB_W-1:0] rgb332_to_444(input logic [PIX_W-1:0] pix);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = pix[R_MSB:R_LSB];
    g = pix[G_MSB:G_LSB];
    b = pix[B_MSB:B_LSB];
    return {r, r[2], g, g[2], b, b};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical pixel counters with raw sync, visible flag and
// line-end / frame-end strobes.
module vga_timing_gen import vga_frame_reader_pkg::*; #(
  parameter int unsigned H_VIS  = DEF_H_VIS,
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned H_SYNC = DEF_H_SYNC,
  parameter int unsigned H_BP   = DEF_H_BP,
  parameter int unsigned V_VIS  = DEF_V_VIS,
  parameter int unsigned V_FP   = DEF_V_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             hsync_on,
  output logic             vsync_on,
  output logic             visible,
  output logic             line_end,
  output logic             frame_end
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VEND  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VEND  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;

  always_comb begin
    line_end  = (hcnt_q == H_LAST);
    frame_end = line_end && (vcnt_q == V_LAST);
    hcnt_d    = line_end ? '0 : hcnt_q + 1'b1;
    vcnt_d    = vcnt_q;
    if (frame_end) begin
      vcnt_d = '0;
    end else if (line_end) begin
      vcnt_d = vcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt     = hcnt_q;
  assign vcnt     = vcnt_q;
  assign hsync_on = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
  assign vsync_on = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
  assign visible  = (hcnt_q < H_VEND) && (vcnt_q < V_VEND);

endmodule

// File: rtl/vga_frame_reader.sv
// Display side of the camera pipeline: reads the RGB332 frame buffer, upscales it by
// 2^SCALE_SHIFT and drives RGB444 VGA with syncs delayed to match the colour path.
module vga_frame_reader import vga_frame_reader_pkg::*; #(
  parameter int unsigned IMG_W       = 160,
  parameter int unsigned IMG_H       = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned H_VIS       = DEF_H_VIS,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_VIS       = DEF_V_VIS,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter int unsigned RAM_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] DP_RAM_addr_in,
  input  logic [PIX_W-1:0]  DP_RAM_data_in,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              frame_start
);

  localparam int unsigned LAT = 2 + RAM_LAT;

  localparam logic [CNT_W-1:0]  IMG_X_END = CNT_W'(IMG_W << SCALE_SHIFT);
  localparam logic [CNT_W-1:0]  IMG_Y_END = CNT_W'(IMG_H << SCALE_SHIFT);
  localparam logic [7:0]        SUB_LAST  = 8'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);

  logic [CNT_W-1:0] hcnt, vcnt;
  logic             hsync_on, vsync_on, visible, line_end, frame_end;
  logic             img_valid, img_line, fs_raw;

  vga_timing_gen #(
    .H_VIS  (H_VIS),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .hsync_on  (hsync_on),
    .vsync_on  (vsync_on),
    .visible   (visible),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  assign img_line  = (vcnt < IMG_Y_END);
  assign img_valid = visible && img_line && (hcnt < IMG_X_END);
  assign fs_raw    = (hcnt == '0) && (vcnt == '0);

  // Address generation: sub-counters replicate each stored pixel/line 2^SCALE_SHIFT times.
  logic [ADDR_W-1:0] col_q, col_d, row_base_q, row_base_d, addr_q;
  logic [7:0]        sub_x_q, sub_x_d, sub_y_q, sub_y_d;

  always_comb begin
    col_d      = col_q;
    sub_x_d    = sub_x_q;
    row_base_d = row_base_q;
    sub_y_d    = sub_y_q;
    if (img_valid) begin
      if (sub_x_q == SUB_LAST) begin
        sub_x_d = '0;
        col_d   = col_q + 1'b1;
      end else begin
        sub_x_d = sub_x_q + 1'b1;
      end
    end
    if (line_end) begin
      col_d   = '0;
      sub_x_d = '0;
      if (img_line) begin
        if (sub_y_q == SUB_LAST) begin
          sub_y_d    = '0;
          row_base_d = row_base_q + ROW_STEP;
        end else begin
          sub_y_d = sub_y_q + 1'b1;
        end
      end
    end
    if (frame_end) begin
      row_base_d = '0;
      sub_y_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      sub_x_q    <= '0;
      row_base_q <= '0;
      sub_y_q    <= '0;
      addr_q     <= '0;
    end else begin
      col_q      <= col_d;
      sub_x_q    <= sub_x_d;
      row_base_q <= row_base_d;
      sub_y_q    <= sub_y_d;
      if (img_valid) begin
        addr_q <= row_base_q + col_q;
      end
    end
  end

  assign DP_RAM_addr_in = addr_q;

  // Valid is needed one stage early, where the RAM data lands at the colour register.
  logic [LAT-1:0] hs_pipe, vs_pipe, fs_pipe;
  logic [LAT-2:0] valid_pipe;
  logic [RGB_W-1:0] rgb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_pipe    <= '0;
      vs_pipe    <= '0;
      fs_pipe    <= '0;
      valid_pipe <= '0;
      rgb_q      <= '0;
    end else begin
      hs_pipe    <= {hs_pipe[LAT-2:0], hsync_on};
      vs_pipe    <= {vs_pipe[LAT-2:0], vsync_on};
      fs_pipe    <= {fs_pipe[LAT-2:0], fs_raw};
      valid_pipe <= {valid_pipe[LAT-3:0], img_valid};
      if (valid_pipe[LAT-2]) begin
        rgb_q <= rgb332_to_444(DP_RAM_data_in);
      end else begin
        rgb_q <= '0;
      end
    end
  end

  assign vga_hsync   = ~hs_pipe[LAT-1];
  assign vga_vsync   = ~vs_pipe[LAT-1];
  assign frame_start = fs_pipe[LAT-1];
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Display-side stage of the camera pipeline: consumes the RGB332 frame buffer that the capture stage writes into the dual-port RAM and drives a 640x480@60 Hz VGA output. It generates the VGA timing and reads the RAM's second port with a registered address. It upscales the stored image by an integer power of two and expands RGB332 to 12-bit RGB444 for the board DAC. It runs in the 25 MHz pixel clock domain, fully independent of the camera's pclk.

## Interface
- IMG_W, 160: stored image width in pixels.
- IMG_H, 120: stored image height in lines.
- SCALE_SHIFT, 2: upscale factor is 2^SCALE_SHIFT per axis. IMG_W<<SCALE_SHIFT must not exceed H_VIS, and IMG_H<<SCALE_SHIFT must not exceed V_VIS.
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48: horizontal timing in pixel clocks.
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33: vertical timing in lines.
- RAM_LAT, 1: read latency of the RAM port in clocks.
- clk  in  1  25 MHz pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- DP_RAM_addr_in  out  15  read address to the RAM's second port.
- DP_RAM_data_in  in  8  RAM read data, RGB332 {R[2:0],G[2:0],B[1:0]}.
- vga_hsync  out  1  horizontal sync, active low.
- vga_vsync  out  1  vertical sync, active low.
- vga_r, vga_g, vga_b  out  4 each  colour; zero outside the image area.
- frame_start  out  1  one-clock pulse aligned with output pixel (0,0).

## Operation
- hcnt runs 0..H_TOTAL-1, where H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800. vcnt runs 0..V_TOTAL-1 (525) and advances when hcnt wraps. Both counters wrap to 0.
- The sync pulses are active in the following counter ranges:
  - hsync: H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC.
  - vsync: V_VIS+V_FP <= vcnt < V_VIS+V_FP+V_SYNC.
- img_valid = (hcnt < IMG_W<<SCALE_SHIFT) && (vcnt < IMG_H<<SCALE_SHIFT).
- Address generation uses no multiplier:
  - row_base holds the address of the first pixel of the current stored line.
  - col increments once per 2^SCALE_SHIFT valid clocks.
  - At the end of each visible line, col clears.
  - row_base += IMG_W after every 2^SCALE_SHIFT-th visible line.
  - row_base clears at vcnt wrap.
  - Address = row_base + col. Max address IMG_W*IMG_H-1 = 19199, which fits in 15 bits.
- DP_RAM_addr_in is held at its last value when img_valid=0. The read data is then ignored.
- Colour expansion is registered:
  - r = {R, R[2]}
  - g = {G, G[2]}
  - b = {B, B}
  - Result is forced to 0 when the delayed img_valid is 0.
- hsync, vsync, img_valid and frame_start travel through a delay line so they stay aligned with the colour data.
- Reset:
  - hcnt, vcnt, row_base, col and DP_RAM_addr_in clear to 0.
  - Delay line clears.
  - vga_hsync=1, vga_vsync=1, colours=0, frame_start=0.
  - Reset mid-frame restarts at pixel (0,0) one clock after rst deasserts. No partial sync pulse is extended.

## Timing
- Latency from counter state (h,v) to outputs is L = 2 + RAM_LAT clocks (3 by default):
  - address register: 1 clock.
  - RAM read: RAM_LAT clocks.
  - colour register: 1 clock.
- Syncs and frame_start carry the same L delay, so the relative VGA timing is exact.
- frame_start is high for exactly one clock per frame, on the clock where the output pixel at (0,0) is presented.
- Counter boundaries:
  - hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1 in the same clock → both wrap to 0 in the next clock; row_base and col clear.
  - Last stored pixel (IMG_W-1, IMG_H-1) is repeated 2^SCALE_SHIFT times in x and lines in y, then colour goes to 0.
- The RAM is read-only from this port. Concurrent writes from the capture side may tear the image; this block does no arbitration.

## Structure
- Shared package: VGA timing constants, the RGB332 field positions, and the RGB332→RGB444 expansion function. The capture stage uses the same field positions.
- One natural sub-module: vga_timing_gen, which owns hcnt, vcnt, raw syncs, visible flag and line-end/frame-end strobes.
- The address generator, delay line and colour stage live in the top module.

## Test plan
- Reset then free-run with default parameters:
  - hsync low for 96 clocks, every 800 clocks.
  - vsync low for 2 lines (1600 clocks), every 525 lines.
  - First frame_start occurs 3 clocks after rst deasserts.
- RAM model returns data = address[7:0] with 1-clock latency:
  - Output pixel (x,y) visible: colour = expand(((y>>2)*160+(x>>2)) & 8'hFF).
  - Outside the image area: colour = 0.
- Address sequence: on line y=0 the address steps 0,0,0,0,1,1,1,1,…,159.
  - Lines 1–3 repeat the same sequence.
  - Line 4 starts at 160.
  - Line 479 ends at 19199.
- Small config: IMG_W=16, IMG_H=12, SCALE_SHIFT=0.
  - Colour nonzero only for x<16, y<12.
  - Address reaches 191, then holds.
- Colour expansion corner cases:
  - 8'hFF → r=g=4'hF, b=4'hF.
  - 8'h00 → 0.
  - 8'b100_010_01 → r=4'b1001, g=4'b0100, b=4'b0101.
- Assert rst for 1 clock at hcnt=700, vcnt=200:
  - Next clock: hsync=1, vsync=1, colours=0.
  - Counters restart at (0,0).
  - frame_start fires 3 clocks after rst drops.
